safe_dial_clicker: RTL and testbench

//   Parametrised safe-dial solver, second generation. Accepts rotation commands over a

---
 rtl/safe_dial_clicker.sv | 137 +++++++++++++
 tb/tb_safe_dial_clicker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/safe_dial_clicker.sv
// Safe-dial solver: accepts rotation commands, reduces the distance with a bit-serial
// restoring divider, then updates the dial position, zero-landing count and zero-pass count.
//
// state | meaning
// IDLE  | ready for a command
// DIV   | one restoring-division step per cycle, MSB first
// UPD   | apply quotient/remainder to position and counters, pulse done_o
module safe_dial_clicker #(
  parameter int DIAL_SIZE  = 100,
  parameter int DIAL_START = 50,
  parameter int DIST_W     = 32,
  parameter int CNT_W      = 32,
  localparam int PW        = $clog2(DIAL_SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              direction_i,
  input  logic [DIST_W-1:0] distance_i,
  output logic [PW-1:0]     position_o,
  output logic [CNT_W-1:0]  land_count_o,
  output logic [CNT_W-1:0]  pass_count_o,
  output logic              done_o
);

  localparam int BW = (DIST_W > 1) ? $clog2(DIST_W) : 1;
  localparam logic [PW:0]   DS_W    = (PW+1)'(DIAL_SIZE);
  localparam logic [PW-1:0] START_W = PW'(DIAL_START);

  typedef enum logic [1:0] {IDLE, DIV, UPD} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [CNT_W-1:0]  land_q, land_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [PW:0]       rem_q, rem_d;
  logic [DIST_W-1:0] div_q, div_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              dir_q, dir_d;
  logic              done_q, done_d;

  logic [PW:0] rem_shift, rem_next, p_ext, s_r, new_r, new_l, new_pos;
  logic        ge, wrap_r, hit_l, extra;

  always_comb begin
    // div_q holds the dividend on entry and the quotient after the last step
    rem_shift = {rem_q[PW-1:0], div_q[DIST_W-1]};
    ge        = (rem_shift >= DS_W);
    rem_next  = ge ? (rem_shift - DS_W) : rem_shift;

    p_ext   = {1'b0, pos_q};
    s_r     = p_ext + rem_q;
    wrap_r  = (s_r >= DS_W);
    new_r   = wrap_r ? (s_r - DS_W) : s_r;
    new_l   = (rem_q > p_ext) ? (p_ext + DS_W - rem_q) : (p_ext - rem_q);
    hit_l   = (pos_q != '0) && (rem_q >= p_ext);
    new_pos = dir_q ? new_r : new_l;
    extra   = dir_q ? wrap_r : hit_l;
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    land_d    = land_q;
    pass_d    = pass_q;
    rem_d     = rem_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          div_d     = distance_i;
          rem_d     = '0;
          bit_cnt_d = BW'(DIST_W - 1);
          dir_d     = direction_i;
          state_d   = DIV;
        end
      end
      DIV: begin
        rem_d     = rem_next;
        div_d     = {div_q[DIST_W-2:0], ge};
        bit_cnt_d = bit_cnt_q - 1'b1;
        if (bit_cnt_q == '0) state_d = UPD;
      end
      UPD: begin
        pos_d   = new_pos[PW-1:0];
        land_d  = land_q + CNT_W'(new_pos == '0);
        pass_d  = pass_q + CNT_W'(div_q) + CNT_W'(extra);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
      pos_d   = START_W;
      land_d  = '0;
      pass_d  = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pos_q     <= START_W;
      land_q    <= '0;
      pass_q    <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      bit_cnt_q <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      land_q    <= land_d;
      pass_q    <= pass_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
    end
  end

  assign ready_o      = (state_q == IDLE);
  assign position_o   = pos_q;
  assign land_count_o = land_q;
  assign pass_count_o = pass_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_safe_dial_clicker.sv
// Bench for safe_dial_clicker: a 100-position/32-bit instance and a 7-position/8-bit instance,
// directed cases plus random commands against a modulo-arithmetic dial model.
module tb_safe_dial_clicker;
  localparam int W0 = 32;
  localparam int W1 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  logic        valid0 = 1'b0, dir0 = 1'b0, ready0, done0;
  logic [31:0] dist0 = '0, land0, pass0;
  logic [6:0]  pos0;
  logic        valid1 = 1'b0, dir1 = 1'b0, ready1, done1;
  logic [7:0]  dist1 = '0;
  logic [31:0] land1, pass1;
  logic [2:0]  pos1;

  safe_dial_clicker u0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid0), .ready_o(ready0),
    .direction_i(dir0), .distance_i(dist0), .position_o(pos0),
    .land_count_o(land0), .pass_count_o(pass0), .done_o(done0));

  safe_dial_clicker #(.DIAL_SIZE(7), .DIAL_START(0), .DIST_W(8)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid1), .ready_o(ready1),
    .direction_i(dir1), .distance_i(dist1), .position_o(pos1),
    .land_count_o(land1), .pass_count_o(pass1), .done_o(done1));

  int checks = 0;
  int failures = 0;
  int acc0 = 0;
  int nd0 = 0;
  longint m_pos[2], m_land[2], m_pass[2];

  always @(posedge clk) if (valid0 && ready0) acc0++;
  always @(posedge clk) if (done0) nd0++;

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  function automatic void chk(string tag, bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s", tag);
    end
  endfunction

  function automatic void model_reset();
    m_pos[0] = 50; m_pos[1] = 0;
    m_land[0] = 0; m_land[1] = 0;
    m_pass[0] = 0; m_pass[1] = 0;
  endfunction

  // Count every click that points at zero, then land where the dial stops.
  function automatic void model(int inst, bit dir, longint d);
    longint n = (inst != 0) ? 7 : 100;
    longint p = m_pos[inst];
    longint np, hits;
    if (dir) begin
      np = (p + d) % n;
      hits = (p + d) / n;
    end else begin
      np = (p - (d % n) + n) % n;
      if (p == 0) hits = d / n;
      else if (d >= p) hits = 1 + (d - p) / n;
      else hits = 0;
    end
    m_pos[inst] = np;
    m_pass[inst] += hits;
    if (np == 0) m_land[inst]++;
  endfunction

  task automatic check_state(int inst, string tag);
    if (inst == 0) begin
      chk({tag, " pos"},  pos0  === 7'(m_pos[0]));
      chk({tag, " land"}, land0 === 32'(m_land[0]));
      chk({tag, " pass"}, pass0 === 32'(m_pass[0]));
    end else begin
      chk({tag, " pos"},  pos1  === 3'(m_pos[1]));
      chk({tag, " land"}, land1 === 32'(m_land[1]));
      chk({tag, " pass"}, pass1 === 32'(m_pass[1]));
    end
  endtask

  // Entered at the negedge right after the accepting edge, with valid already dropped.
  task automatic finish_cmd(int inst, bit dir, logic [31:0] d, string tag);
    int lat = 0;
    int w = (inst != 0) ? W1 : W0;
    while (!((inst != 0) ? done1 : done0) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat == w + 1);
    model(inst, dir, (inst != 0) ? longint'(d[7:0]) : longint'(d));
    check_state(inst, tag);
    @(negedge clk);
    chk({tag, " done_single"}, ((inst != 0) ? done1 : done0) === 1'b0);
  endtask

  task automatic send(int inst, bit dir, logic [31:0] d, string tag);
    chk({tag, " ready_idle"}, ((inst != 0) ? ready1 : ready0) === 1'b1);
    if (inst == 0) begin valid0 = 1'b1; dir0 = dir; dist0 = d; end
    else begin valid1 = 1'b1; dir1 = dir; dist1 = d[7:0]; end
    @(negedge clk);
    valid0 = 1'b0; valid1 = 1'b0;
    finish_cmd(inst, dir, d, tag);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  bit          t1_dir [10] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0};
  int unsigned t1_dist[10] = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};

  initial begin
    int acc_start, nd_start, stray;
    bit rd;
    logic [31:0] rdist;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset ready", ready0 === 1'b1);
    chk("reset done", done0 === 1'b0);
    check_state(0, "reset");
    check_state(1, "reset_small");
    rst_n = 1'b1;
    @(negedge clk);

    nd_start = nd0;
    for (int i = 0; i < 10; i++) send(0, t1_dir[i], t1_dist[i], "example");
    chk("example pos", pos0 === 7'd32);
    chk("example land", land0 === 32'd3);
    chk("example pass", pass0 === 32'd6);
    chk("example dones", (nd0 - nd_start) == 10);

    do_clear();
    check_state(0, "clear");
    send(0, 1'b1, 32'd1000, "R1000");
    chk("R1000 pass", pass0 === 32'd10);
    send(0, 1'b0, 32'd50, "L50");
    chk("L50 pos", pos0 === 7'd0);
    send(0, 1'b0, 32'd100, "L100");
    chk("L100 land", land0 === 32'd2);
    chk("L100 pass", pass0 === 32'd12);

    do_clear();
    send(0, 1'b1, 32'hFFFF_FFFF, "max_dist");
    chk("max_dist pos", pos0 === 7'd45);
    chk("max_dist pass", pass0 === 32'd42949673);

    acc_start = acc0;
    valid0 = 1'b1; dir0 = 1'b1; dist0 = 32'd5;
    for (int i = 0; i <= W0; i++) begin
      @(negedge clk);
      chk("bp ready_low", ready0 === 1'b0);
      chk("bp no_done", done0 === 1'b0);
    end
    @(negedge clk);
    chk("bp ready_back", ready0 === 1'b1);
    chk("bp done", done0 === 1'b1);
    model(0, 1'b1, 5);
    check_state(0, "bp first");
    dir0 = 1'b0; dist0 = 32'd3;
    @(negedge clk);
    valid0 = 1'b0;
    chk("bp accepts", (acc0 - acc_start) == 2);
    finish_cmd(0, 1'b0, 32'd3, "bp second");

    for (int i = 0; i < 30; i++) begin
      rd = 1'($urandom_range(0, 1));
      rdist = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 350));
      send(0, rd, rdist, "rand");
    end

    do_clear();
    send(1, 1'b0, 32'd0, "small L0");
    chk("small L0 land", land1 === 32'd1);
    chk("small L0 pass", pass1 === 32'd0);
    send(1, 1'b1, 32'd7, "small R7");
    chk("small R7 pass", pass1 === 32'd1);
    chk("small R7 land", land1 === 32'd2);
    send(1, 1'b0, 32'd15, "small L15");
    chk("small L15 pos", pos1 === 3'd6);
    chk("small L15 pass", pass1 === 32'd3);
    for (int i = 0; i < 25; i++) begin
      rd = 1'($urandom_range(0, 1));
      send(1, rd, 32'($urandom_range(0, 255)), "rand_small");
    end

    valid0 = 1'b1; dir0 = 1'b1; dist0 = 32'd77;
    @(negedge clk);
    valid0 = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst ready", ready0 === 1'b1);
    check_state(0, "async_rst");
    check_state(1, "async_rst_small");
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done0) stray++;
    end
    chk("async_rst no_done", stray == 0);
    send(0, 1'b0, 32'd60, "post_rst");

    valid0 = 1'b1; dir0 = 1'b1; dist0 = 32'd33;
    @(negedge clk);
    valid0 = 1'b0;
    repeat (W0) @(negedge clk);
    chk("clr_upd in_upd", ready0 === 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    chk("clr_upd done", done0 === 1'b0);
    chk("clr_upd ready", ready0 === 1'b1);
    check_state(0, "clr_upd");
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done0) stray++;
    end
    chk("clr_upd no_done", stray == 0);
    send(0, 1'b1, 32'd50, "post_clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
